// File: rtl/rf_sequencer.sv
// Step-button driven sequencer for the 4x4-bit lab register file.
// Each debounced press runs one LOAD/MOVE/ADD/SWAP as a short read/write
// sequence. Every RF-facing output is a flop, so sw_clk is glitch-free.
module rf_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       fpga_clk,
  input  logic       rst_n,
  input  logic       sw_step,
  input  logic [1:0] op,
  input  logic [1:0] src,
  input  logic [1:0] dst,
  input  logic [3:0] imm,
  input  logic [3:0] rf_data,
  output logic [3:0] DataIn,
  output logic [1:0] AddrX,
  output logic [1:0] AddrY,
  output logic       RdX,
  output logic       RdY,
  output logic       WrX,
  output logic       sw_clk,
  output logic [3:0] sm_state,
  output logic       busy
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLatch   = 3'd1,
    StRdSrc   = 3'd2,
    StRdDst   = 3'd3,
    StWrSetup = 3'd4,
    StWrPulse = 3'd5,
    StWrHold  = 3'd6,
    StDone    = 3'd7
  } state_e;

  localparam logic [1:0] OpLoad = 2'b00;
  localparam logic [1:0] OpMove = 2'b01;
  localparam logic [1:0] OpAdd  = 2'b10;

  localparam logic [CNT_W-1:0] DebLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_e           state_q, state_d;
  logic             sync1_q, sync1_d, sync2_q, sync2_d;
  logic             deb_q, deb_d, deb_prev_q, deb_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_evt;

  logic [1:0] op_q, op_d, src_q, src_d, dst_q, dst_d, waddr_q, waddr_d;
  logic [3:0] imm_q, imm_d, tmp_a_q, tmp_a_d, tmp_b_q, tmp_b_d, wdata_q, wdata_d;
  logic       second_q, second_d;

  logic [3:0] data_in_q, data_in_d;
  logic [1:0] addr_x_q, addr_x_d, addr_y_q, addr_y_d;
  logic       rd_x_q, rd_x_d, rd_y_q, rd_y_d, wr_x_q, wr_x_d;
  logic       sw_clk_q, sw_clk_d, busy_q, busy_d;

  // Synchronizer and debouncer: level flips after DEBOUNCE_CYCLES differing samples.
  always_comb begin
    sync1_d    = sw_step;
    sync2_d    = sync1_q;
    deb_d      = deb_q;
    deb_prev_d = deb_q;
    cnt_d      = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == DebLast) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign step_evt = deb_q & ~deb_prev_q;

  // Next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    src_d    = src_q;
    dst_d    = dst_q;
    imm_d    = imm_q;
    tmp_a_d  = tmp_a_q;
    tmp_b_d  = tmp_b_q;
    wdata_d  = wdata_q;
    waddr_d  = waddr_q;
    second_d = second_q;
    case (state_q)
      StIdle: begin
        if (step_evt) begin
          op_d    = op;
          src_d   = src;
          dst_d   = dst;
          imm_d   = imm;
          state_d = StLatch;
        end
      end
      StLatch: begin
        if (op_q == OpLoad) begin
          wdata_d = imm_q;
          waddr_d = dst_q;
          state_d = StWrSetup;
        end else begin
          state_d = StRdSrc;
        end
      end
      StRdSrc: begin
        tmp_a_d = rf_data;
        if (op_q == OpMove) begin
          wdata_d = rf_data;
          waddr_d = dst_q;
          state_d = StWrSetup;
        end else begin
          state_d = StRdDst;
        end
      end
      StRdDst: begin
        tmp_b_d = rf_data;
        waddr_d = dst_q;
        state_d = StWrSetup;
        if (op_q == OpAdd) begin
          wdata_d = tmp_a_q + rf_data;  // carry dropped
        end else begin
          wdata_d  = tmp_a_q;
          second_d = 1'b1;
        end
      end
      StWrSetup: state_d = StWrPulse;
      StWrPulse: state_d = StWrHold;
      StWrHold: begin
        if (second_q) begin
          second_d = 1'b0;
          wdata_d  = tmp_b_q;
          waddr_d  = src_q;
          state_d  = StWrSetup;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        // Held button keeps us here, so it never re-triggers.
        if (!deb_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output values decoded from the state being entered, so outputs are pure flops.
  always_comb begin
    data_in_d = '0;
    addr_x_d  = '0;
    addr_y_d  = '0;
    rd_x_d    = 1'b0;
    rd_y_d    = 1'b0;
    wr_x_d    = 1'b0;
    sw_clk_d  = 1'b0;
    busy_d    = 1'b0;
    case (state_d)
      StLatch: busy_d = 1'b1;
      StRdSrc: begin
        addr_y_d = src_d;
        rd_y_d   = 1'b1;
        busy_d   = 1'b1;
      end
      StRdDst: begin
        addr_x_d = dst_d;
        rd_x_d   = 1'b1;
        busy_d   = 1'b1;
      end
      StWrSetup, StWrPulse, StWrHold: begin
        addr_x_d  = waddr_d;
        data_in_d = wdata_d;
        wr_x_d    = 1'b1;
        sw_clk_d  = (state_d == StWrPulse);
        busy_d    = 1'b1;
      end
      default: ;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge fpga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      cnt_q      <= '0;
      op_q       <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      imm_q      <= '0;
      tmp_a_q    <= '0;
      tmp_b_q    <= '0;
      wdata_q    <= '0;
      waddr_q    <= '0;
      second_q   <= 1'b0;
      data_in_q  <= '0;
      addr_x_q   <= '0;
      addr_y_q   <= '0;
      rd_x_q     <= 1'b0;
      rd_y_q     <= 1'b0;
      wr_x_q     <= 1'b0;
      sw_clk_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      imm_q      <= imm_d;
      tmp_a_q    <= tmp_a_d;
      tmp_b_q    <= tmp_b_d;
      wdata_q    <= wdata_d;
      waddr_q    <= waddr_d;
      second_q   <= second_d;
      data_in_q  <= data_in_d;
      addr_x_q   <= addr_x_d;
      addr_y_q   <= addr_y_d;
      rd_x_q     <= rd_x_d;
      rd_y_q     <= rd_y_d;
      wr_x_q     <= wr_x_d;
      sw_clk_q   <= sw_clk_d;
      busy_q     <= busy_d;
    end
  end

  assign DataIn   = data_in_q;
  assign AddrX    = addr_x_q;
  assign AddrY    = addr_y_q;
  assign RdX      = rd_x_q;
  assign RdY      = rd_y_q;
  assign WrX      = wr_x_q;
  assign sw_clk   = sw_clk_q;
  assign busy     = busy_q;
  assign sm_state = {1'b0, state_q};

endmodule
